// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_pkg
// Description : Shared helpers for the synchronous FIFO: phase-wrap pointer
//               increment and occupancy calculation from phase-bit pointers.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_pkg;

   // Advance a phase-bit pointer. The low ptr_w-1 bits are the index and
   // the MSB is the phase. Reaching depth-1 wraps the index to 0 and toggles
   // the phase, which keeps non-power-of-two depths unambiguous.
   function automatic logic [31:0] fifo_ptr_incr(input logic [31:0] ptr,
                                                  input int          ptr_w,
                                                  input int          depth);
      logic [31:0] phase_bit;
      logic [31:0] idx_mask;
      logic [31:0] idx;
      logic [31:0] phase;
      phase_bit = 32'd1 << (ptr_w - 1);
      idx_mask  = phase_bit - 32'd1;
      idx       = ptr & idx_mask;
      phase     = ptr & phase_bit;
      if (idx == 32'(depth - 1)) begin
         return phase ^ phase_bit;
      end
      return phase | (idx + 32'd1);
   endfunction

   // Occupancy from write and read pointers. Equal phases mean the writer is
   // in the same lap as the reader; differing phases mean it has wrapped.
   function automatic logic [31:0] fifo_depth(input logic [31:0] wptr,
                                               input logic [31:0] rptr,
                                               input int          ptr_w,
                                               input int          depth);
      logic [31:0] phase_bit;
      logic [31:0] idx_mask;
      logic [31:0] widx;
      logic [31:0] ridx;
      phase_bit = 32'd1 << (ptr_w - 1);
      idx_mask  = phase_bit - 32'd1;
      widx      = wptr & idx_mask;
      ridx      = rptr & idx_mask;
      if ((wptr & phase_bit) == (rptr & phase_bit)) begin
         return widx - ridx;
      end
      return 32'(depth) - ridx + widx;
   endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_sync_mem.sv
`default_nettype none
// ============================================================================
// Module      : fifo_sync_mem
// Description : DEPTH x WIDTH flop array, one write port and one
//               combinational read port. Storage has no reset.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_sync_mem #(
   parameter int WIDTH  = 16,
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 2
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [WIDTH-1:0]  wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [WIDTH-1:0]  rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   // Write port: capture data into the addressed entry.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule
`default_nettype wire

// File: rtl/fifo_sync_hs.sv
`default_nettype none
// ============================================================================
// Module      : fifo_sync_hs
// Description : Synchronous valid/ready FIFO with phase-bit pointers,
//               occupancy reporting and optional duplicated-pointer checking.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_sync_hs
   import fifo_pkg::*;
#(
   parameter int WIDTH                = 16,
   parameter int DEPTH                = 4,
   parameter bit OUTPUT_ZERO_IF_EMPTY = 1'b1,
   parameter bit SECURE               = 1'b0,
   localparam int DEPTH_W             = $clog2(DEPTH + 1)
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               clr_i,
   input  logic               wvalid_i,
   output logic               wready_o,
   input  logic [WIDTH-1:0]   wdata_i,
   output logic               rvalid_o,
   input  logic               rready_i,
   output logic [WIDTH-1:0]   rdata_o,
   output logic               full_o,
   output logic [DEPTH_W-1:0] depth_o,
   output logic               err_o
);

   // Pointer is index plus one phase bit; a single-entry FIFO still needs a
   // one-bit index so the phase bit has somewhere to sit.
   localparam int PTR_W = (($clog2(DEPTH) + 1) < 2) ? 2 : ($clog2(DEPTH) + 1);
   localparam int IDX_W = PTR_W - 1;

   logic [PTR_W-1:0] wptr;
   logic [PTR_W-1:0] rptr;
   logic [PTR_W-1:0] wptr_inc;
   logic [PTR_W-1:0] rptr_inc;
   logic             empty;
   logic             full;
   logic             push;
   logic             pop;
   logic             flush;
   logic [WIDTH-1:0] mem_rdata;

   assign wptr_inc = PTR_W'(fifo_ptr_incr(32'(wptr), PTR_W, DEPTH));
   assign rptr_inc = PTR_W'(fifo_ptr_incr(32'(rptr), PTR_W, DEPTH));

   assign empty = (wptr == rptr);
   assign full  = (wptr[PTR_W-1] != rptr[PTR_W-1]) &&
                  (wptr[IDX_W-1:0] == rptr[IDX_W-1:0]);

   // Handshakes are gated by reset so nothing is offered while it is held.
   assign wready_o = ~full & ~rst_i;
   assign rvalid_o = ~empty & ~rst_i;
   assign push     = wvalid_i & wready_o;
   assign pop      = rvalid_o & rready_i;
   assign flush    = rst_i | clr_i;

   assign full_o  = full;
   assign depth_o = DEPTH_W'(fifo_depth(32'(wptr), 32'(rptr), PTR_W, DEPTH));

   // Pointer update; a flush overrides any handshake seen in the same cycle.
   always_ff @(posedge clk_i) begin
      if (flush) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (push) begin
            wptr <= wptr_inc;
         end
         if (pop) begin
            rptr <= rptr_inc;
         end
      end
   end

   // A write discarded by clr_i is also kept out of storage.
   fifo_sync_mem #(
      .WIDTH  (WIDTH),
      .DEPTH  (DEPTH),
      .ADDR_W (IDX_W)
   ) u_mem (
      .clk   (clk_i),
      .we    (push & ~clr_i),
      .waddr (wptr[IDX_W-1:0]),
      .wdata (wdata_i),
      .raddr (rptr[IDX_W-1:0]),
      .rdata (mem_rdata)
   );

   assign rdata_o = (OUTPUT_ZERO_IF_EMPTY && empty) ? '0 : mem_rdata;

   if (SECURE) begin : g_secure
      logic [PTR_W-1:0] wptr_shadow_q;
      logic [PTR_W-1:0] rptr_shadow_q;
      // Nets give a single observable point for the shadow values.
      wire  [PTR_W-1:0] wptr_shadow = wptr_shadow_q;
      wire  [PTR_W-1:0] rptr_shadow = rptr_shadow_q;

      // Shadow pointers advance on the primary conditions but from their own
      // state, so a corrupted copy stays divergent until flushed.
      always_ff @(posedge clk_i) begin
         if (flush) begin
            wptr_shadow_q <= '0;
            rptr_shadow_q <= '0;
         end else begin
            if (push) begin
               wptr_shadow_q <= PTR_W'(fifo_ptr_incr(32'(wptr_shadow), PTR_W, DEPTH));
            end
            if (pop) begin
               rptr_shadow_q <= PTR_W'(fifo_ptr_incr(32'(rptr_shadow), PTR_W, DEPTH));
            end
         end
      end

      assign err_o = (wptr != wptr_shadow) | (rptr != rptr_shadow);
   end else begin : g_no_secure
      assign err_o = 1'b0;
   end

endmodule
`default_nettype wire

// File: tb/tb_fifo_sync_hs.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_sync_hs
// Description : Self-checking bench for fifo_sync_hs. Three instances
//               (Depth 4, Depth 3, Depth 4 secure) share one stimulus; a
//               queue model checks every cycle, literals pin key points.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_sync_hs;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        clr;
   logic        wvalid;
   logic        rready;
   logic [15:0] wdata;

   logic        rv0, wr0, fu0, er0;
   logic        rv1, wr1, fu1, er1;
   logic        rv2, wr2, fu2, er2;
   logic [15:0] rd0, rd1, rd2;
   logic [2:0]  dp0, dp2;
   logic [1:0]  dp1;

   int total = 0;
   int bad   = 0;
   bit started = 1'b0;
   bit err_exp = 1'b0;

   logic [15:0] mq [3][$];
   int          cap [3] = '{4, 3, 4};

   fifo_sync_hs #(.WIDTH(16), .DEPTH(4), .OUTPUT_ZERO_IF_EMPTY(1'b1), .SECURE(1'b0)) dut4 (
      .clk_i(clk), .rst_i(rst), .clr_i(clr), .wvalid_i(wvalid), .wready_o(wr0),
      .wdata_i(wdata), .rvalid_o(rv0), .rready_i(rready), .rdata_o(rd0),
      .full_o(fu0), .depth_o(dp0), .err_o(er0));

   fifo_sync_hs #(.WIDTH(16), .DEPTH(3), .OUTPUT_ZERO_IF_EMPTY(1'b1), .SECURE(1'b0)) dut3 (
      .clk_i(clk), .rst_i(rst), .clr_i(clr), .wvalid_i(wvalid), .wready_o(wr1),
      .wdata_i(wdata), .rvalid_o(rv1), .rready_i(rready), .rdata_o(rd1),
      .full_o(fu1), .depth_o(dp1), .err_o(er1));

   fifo_sync_hs #(.WIDTH(16), .DEPTH(4), .OUTPUT_ZERO_IF_EMPTY(1'b1), .SECURE(1'b1)) dut_s (
      .clk_i(clk), .rst_i(rst), .clr_i(clr), .wvalid_i(wvalid), .wready_o(wr2),
      .wdata_i(wdata), .rvalid_o(rv2), .rready_i(rready), .rdata_o(rd2),
      .full_o(fu2), .depth_o(dp2), .err_o(er2));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h at t=%0t", name, act, exp, $time);
      end
   endtask

   // Queue model: a flush empties the FIFO; otherwise a pop needs a stored
   // word and a push needs a free slot, both judged on pre-edge occupancy.
   always @(posedge clk) begin
      started = 1'b1;
      for (int k = 0; k < 3; k++) begin
         int  sz;
         bit  do_pop;
         bit  do_push;
         sz = mq[k].size();
         if (rst || clr) begin
            mq[k].delete();
         end else begin
            do_pop  = (sz > 0) && rready;
            do_push = (sz < cap[k]) && wvalid;
            if (do_pop)  void'(mq[k].pop_front());
            if (do_push) mq[k].push_back(wdata);
         end
      end
   end

   task automatic cmp_one(input int k, input logic v_rv, input logic v_wr,
                          input logic v_fu, input logic v_er,
                          input logic [15:0] v_rd, input logic [2:0] v_dp);
      int          sz;
      logic [15:0] hd;
      sz = mq[k].size();
      hd = (sz > 0) ? mq[k][0] : 16'h0;
      check($sformatf("m%0d_rvalid", k), 32'(v_rv), 32'(!rst && sz > 0));
      check($sformatf("m%0d_wready", k), 32'(v_wr), 32'(!rst && sz < cap[k]));
      check($sformatf("m%0d_full", k),   32'(v_fu), 32'(sz == cap[k]));
      check($sformatf("m%0d_depth", k),  32'(v_dp), 32'(sz));
      check($sformatf("m%0d_rdata", k),  32'(v_rd), 32'(hd));
      check($sformatf("m%0d_err", k),    32'(v_er), 32'((k == 2) ? err_exp : 1'b0));
   endtask

   // Per-cycle comparison on the falling edge, away from state updates.
   always @(negedge clk) begin
      if (started) begin
         cmp_one(0, rv0, wr0, fu0, er0, rd0, dp0);
         cmp_one(1, rv1, wr1, fu1, er1, rd1, {1'b0, dp1});
         cmp_one(2, rv2, wr2, fu2, er2, rd2, dp2);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; clr = 1'b0; wvalid = 1'b0; rready = 1'b0; wdata = 16'h0;
      tick();
      check("rst_wready", 32'(wr0), 32'd0);
      check("rst_rvalid", 32'(rv0), 32'd0);
      tick();
      rst = 1'b0;
      #1;
      check("post_rst_wready", 32'(wr0), 32'd1);
      check("post_rst_depth",  32'(dp0), 32'd0);
      check("post_rst_rdata",  32'(rd0), 32'd0);
      check("post_rst_full",   32'(fu0), 32'd0);

      // Fill Depth=4 with A1..A4, then try a fifth write.
      wvalid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         wdata = 16'hA1 + 16'(i);
         tick();
         check("fill_depth", 32'(dp0), 32'(i + 1));
      end
      check("fill_full",   32'(fu0), 32'd1);
      check("fill_wready", 32'(wr0), 32'd0);
      check("d3_full",     32'(fu1), 32'd1);
      wdata = 16'hA5;
      tick();
      check("overflow_depth", 32'(dp0), 32'd4);
      check("overflow_head",  32'(rd0), 32'hA1);

      // Drain in order.
      wvalid = 1'b0;
      rready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check("drain_data", 32'(rd0), 32'hA1 + 32'(i));
         tick();
      end
      rready = 1'b0;
      check("drained_rvalid", 32'(rv0), 32'd0);
      check("drained_rdata",  32'(rd0), 32'd0);
      check("drained_depth",  32'(dp0), 32'd0);

      // Depth=3 streaming at occupancy 1 across several index wraps.
      wvalid = 1'b1;
      wdata  = 16'd1;
      tick();
      rready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         wdata = 16'(i + 2);
         check("stream_depth", 32'(dp1), 32'd1);
         check("stream_data",  32'(rd1), 32'(i + 1));
         tick();
      end
      check("stream_last", 32'(rd1), 32'd11);
      wvalid = 1'b0;
      tick();
      rready = 1'b0;
      check("stream_empty", 32'(rv1), 32'd0);

      // Full with write and read together: only the pop happens.
      wvalid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         wdata = 16'hB0 + 16'(i);
         tick();
      end
      wdata  = 16'hBF;
      rready = 1'b1;
      tick();
      check("fullrw_depth", 32'(dp0), 32'd3);
      check("fullrw_head",  32'(rd0), 32'hB1);
      check("fullrw_full",  32'(fu0), 32'd0);
      wvalid = 1'b0; rready = 1'b0; clr = 1'b1;
      tick();
      clr = 1'b0;

      // Flush with a concurrent handshake, then reuse.
      wvalid = 1'b1;
      wdata  = 16'hC1; tick();
      wdata  = 16'hC2; tick();
      clr = 1'b1; wdata = 16'hC3; rready = 1'b1;
      tick();
      clr = 1'b0; wvalid = 1'b0; rready = 1'b0;
      check("clr_depth",  32'(dp0), 32'd0);
      check("clr_rvalid", 32'(rv0), 32'd0);
      check("clr_wready", 32'(wr0), 32'd1);
      wvalid = 1'b1; wdata = 16'h55;
      tick();
      wvalid = 1'b0;
      check("clr_reuse_data",   32'(rd0), 32'h55);
      check("clr_reuse_rvalid", 32'(rv0), 32'd1);
      rready = 1'b1;
      tick();
      rready = 1'b0;

      // Mid-stream reset at occupancy 3.
      wvalid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         wdata = 16'hD1 + 16'(i);
         tick();
      end
      wvalid = 1'b0;
      check("pre_rst_depth", 32'(dp0), 32'd3);
      rst = 1'b1;
      #1;
      check("pulse_wready", 32'(wr0), 32'd0);
      check("pulse_rvalid", 32'(rv0), 32'd0);
      tick();
      rst = 1'b0;
      #1;
      check("after_pulse_depth",  32'(dp0), 32'd0);
      check("after_pulse_wready", 32'(wr0), 32'd1);

      // Shadow pointer corruption on the secure instance (pointers are 0).
      force dut_s.g_secure.wptr_shadow = 3'b001;
      err_exp = 1'b1;
      #1;
      check("secure_err_set", 32'(er2), 32'd1);
      tick();
      release dut_s.g_secure.wptr_shadow;
      err_exp = 1'b0;
      #1;
      check("secure_err_clear", 32'(er2), 32'd0);
      tick();
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/fifo_sync_hs.md
# fifo_sync_hs

Synchronous valid/ready FIFO with internal storage, phase-bit read/write pointers and occupancy reporting. It is the buffering primitive that peripherals place between a register-interface producer and a datapath consumer. Any Depth ≥ 1 is supported, including non-power-of-two values. An optional Secure mode duplicates the pointers and flags any divergence between the two copies.

## Interface
- Width, 16: data word width in bits.
- Depth, 4: number of storage entries; must be ≥ 1.
- OutputZeroIfEmpty, 1: when 1, rdata_o is driven to all zeros while the FIFO is empty.
- Secure, 0: when 1, a shadow copy of both pointers is kept and compared.
- clk_i, input, 1: clock; all state updates on its rising edge.
- rst_i, input, 1: reset, synchronous and active-high.
- clr_i, input, 1: synchronous flush of pointers.
- wvalid_i, input, 1: write request.
- wready_o, output, 1: FIFO can accept a write.
- wdata_i, input, Width: write data.
- rvalid_o, output, 1: read data available.
- rready_i, input, 1: consumer takes the head entry.
- rdata_o, output, Width: head entry.
- full_o, output, 1: occupancy equals Depth.
- depth_o, output, DepthW = $clog2(Depth+1): current occupancy, 0..Depth.
- err_o, output, 1: pointer integrity error (Secure only).

## Operation
- Pointer width is PtrW = $clog2(Depth)+1, with a minimum of 2.
  - Low PtrW-1 bits form the index, range 0..Depth-1.
  - The MSB is the phase bit.
- Pointer increment: when the index equals Depth-1, the index goes to 0 and the phase toggles; otherwise index+1 with phase unchanged.
- Push = wvalid_i & wready_o. Push writes mem[widx] <= wdata_i and increments wptr.
- Pop = rvalid_o & rready_i. Pop increments rptr.
- Push and pop may happen in the same cycle; occupancy is then unchanged.
- empty = (wptr == rptr).
- full_o = (phases differ) & (indices equal).
- depth_o:
  - equal phases: widx - ridx;
  - differing phases: Depth - ridx + widx.
  - Computed in DepthW+1 bits, then truncated.
- wready_o = ~full_o & ~rst_i.
- rvalid_o = ~empty & ~rst_i.
- rdata_o = mem[ridx], a combinational read of registered storage. It becomes 0 when empty and OutputZeroIfEmpty=1.
- Full with a pop and wvalid_i in the same cycle: the write is not accepted, because wready_o was 0. There is no pass-through and no write-through when empty.
- clr_i:
  - sets both pointers (and their shadows) to 0 and takes priority over push and pop that cycle;
  - wready_o and rvalid_o are still driven from the current state during the clr_i cycle, but any handshake completed that cycle is discarded;
  - storage contents are not cleared.
- rst_i:
  - has the same effect as clr_i, plus it holds wready_o and rvalid_o at 0 while asserted;
  - may be asserted mid-stream; the in-flight contents are lost.
- Secure=1:
  - shadow pointers update on the same conditions as the primaries;
  - err_o = (wptr != wptr_shadow) | (rptr != rptr_shadow), purely combinational and not sticky.
- Secure=0: err_o is tied to 0.
- Reset values:
  - wptr = rptr = 0.
  - wready_o = 0 while rst_i is high, 1 on the first cycle after.
  - rvalid_o = 0, full_o = 0, depth_o = 0, err_o = 0.
  - rdata_o = 0 when OutputZeroIfEmpty=1, otherwise undefined.

## Timing
- Write-to-read latency is 1 cycle: data pushed at edge N is visible on rdata_o, with rvalid_o=1, in the cycle after edge N.
- full_o, depth_o and wready_o reflect a push or pop in the cycle after the edge that performed it.
- There are no combinational paths:
  - from wvalid_i to rvalid_o or rdata_o;
  - from rready_i to wready_o.
- rdata_o has a combinational path from the pointer register through the read mux only.

## Structure
- Shared package fifo_pkg:
  - function fifo_ptr_incr(ptr, Depth) implementing the phase-wrap increment;
  - function fifo_depth(wptr, rptr, Depth).
- One sub-module, fifo_sync_mem: Depth×Width flop array with one write port (en, addr, data) and one combinational read port; no reset on the storage.
- The top level holds the pointers, shadow pointers, the handshake logic, and the depth, full and err logic.

## Test plan
- Depth=4, Width=16, push 0xA1, 0xA2, 0xA3, 0xA4 with rready_i=0:
  - depth_o runs 1, 2, 3, 4; full_o=1 and wready_o=0 after the 4th push;
  - a 5th wvalid_i is not accepted.
- Then pop 4 with wvalid_i=0 → rdata_o is 0xA1..0xA4 in order; then rvalid_o=0, rdata_o=0, depth_o=0.
- Depth=3, 10 cycles of simultaneous push/pop at occupancy 1, values 1..10:
  - depth_o stays 1 throughout;
  - read order matches write order across several index wraps (2→0) with phase toggles.
- Full FIFO (Depth=4) with wvalid_i=1 and rready_i=1 in the same cycle → the pop occurs, no write occurs, depth_o becomes 3.
- Push 2 entries, then assert clr_i together with wvalid_i and rready_i → the next cycle shows depth_o=0, rvalid_o=0, wready_o=1; a later push of 0x55 reads back 0x55.
- rst_i pulsed for 1 cycle at occupancy 3 → wready_o=0 and rvalid_o=0 during the pulse; afterwards depth_o=0 and wready_o=1.
- Secure=1, force wptr_shadow bit 0 → err_o=1 in the same cycle; releasing the force → err_o=0.
